// File: rtl/sram_ctrl.sv
// sram_ctrl: async-SRAM bank controller arbitrating an instruction read port and a data read/write port.
// Define SRAM_RR_ARB_EN for round-robin arbitration; otherwise the data port has fixed priority.
module sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be_n,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_data_i,
  output logic [DATA_W-1:0]   sram_data_o,
  output logic                sram_data_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [2:0] {IDLE, RD, DONE, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [BE_W-1:0]   wbe_q, wbe_d, be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic              data_first, gnt_data, last_strobe;
`ifdef SRAM_RR_ARB_EN
  logic              rr_data_last_q, rr_data_last_d;
  assign data_first     = ~rr_data_last_q;
  assign rr_data_last_d = (state_q == IDLE && (i_req || d_req)) ? gnt_data : rr_data_last_q;
`else
  assign data_first = 1'b1;
`endif
  assign gnt_data    = d_req & (~i_req | data_first);
  assign last_strobe = cnt_q == 4'(WAIT_CYC);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wbe_d     = wbe_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (i_req || d_req) begin
        sel_d   = gnt_data;
        addr_d  = gnt_data ? d_addr : i_addr;
        state_d = (gnt_data && d_we) ? WR_SETUP : RD;
        wdata_d = (gnt_data && d_we) ? d_wdata : wdata_q;
        wbe_d   = (gnt_data && d_we) ? d_be_n : wbe_q;
      end
      RD: begin
        state_d   = last_strobe ? DONE : RD;
        cnt_d     = last_strobe ? 4'd0 : cnt_q + 4'd1;
        d_rdata_d = (last_strobe && sel_q) ? sram_data_i : d_rdata_q;
        i_rdata_d = (last_strobe && !sel_q) ? sram_data_i : i_rdata_q;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        state_d = last_strobe ? WR_HOLD : WR_PULSE;
        cnt_d   = last_strobe ? 4'd0 : cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // strobes are registered images of the state being entered
    ce_n_d  = state_d inside {IDLE, DONE};
    oe_n_d  = state_d != RD;
    we_n_d  = state_d != WR_PULSE;
    doe_d   = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    be_n_d  = (state_d == RD) ? '0 : doe_d ? wbe_d : '1;
    i_ack_d = state_d == DONE && !sel_d;
    d_ack_d = (state_d == DONE && sel_d) || state_d == WR_HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wbe_q     <= '1;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      be_n_q    <= '1;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef SRAM_RR_ARB_EN
      rr_data_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      be_n_q    <= be_n_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      doe_q     <= doe_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
`ifdef SRAM_RR_ARB_EN
      rr_data_last_q <= rr_data_last_d;
`endif
    end
  end
  assign sram_addr    = addr_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = doe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized and directed bench for sram_ctrl against a behavioural SRAM and reference memory.
module tb_sram_ctrl;
  localparam int WC = 1;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic        i_req, d_req, d_we, i_ack, d_ack;
  logic [19:0] i_addr, d_addr, sram_addr;
  logic [31:0] d_wdata, i_rdata, d_rdata, sram_data_i, sram_data_o;
  logic [3:0]  d_be_n, sram_be_n;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic        i0_req, i0_ack, u0_d_ack, u0_doe, u0_ce_n, u0_oe_n, u0_we_n;
  logic [19:0] i0_addr, u0_addr;
  logic [31:0] i0_rdata, u0_d_rdata, u0_data_i, u0_data_o;
  logic [3:0]  u0_be_n;
  logic [31:0] smem [0:255];
  logic [31:0] ref_mem [0:255];
  int checks = 0, failures = 0, viol = 0;

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be_n(d_be_n),
    .d_rdata(d_rdata), .d_ack(d_ack), .sram_addr(sram_addr), .sram_data_i(sram_data_i),
    .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n));

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_req(i0_req), .i_addr(i0_addr), .i_rdata(i0_rdata), .i_ack(i0_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(20'h0), .d_wdata(32'h0), .d_be_n(4'hF),
    .d_rdata(u0_d_rdata), .d_ack(u0_d_ack), .sram_addr(u0_addr), .sram_data_i(u0_data_i),
    .sram_data_o(u0_data_o), .sram_data_oe(u0_doe), .sram_ce_n(u0_ce_n),
    .sram_oe_n(u0_oe_n), .sram_we_n(u0_we_n), .sram_be_n(u0_be_n));

  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? smem[sram_addr[7:0]] : 32'h0BADF00D;
  assign u0_data_i   = (!u0_ce_n && !u0_oe_n) ? smem[u0_addr[7:0]] : 32'h0BADF00D;
  always @(posedge sram_we_n)
    if (!sram_ce_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) smem[sram_addr[7:0]][8*b +: 8] = sram_data_o[8*b +: 8];

  always @(negedge clk) begin
    if (sram_data_oe && !sram_oe_n) viol++;
    if (!sram_we_n && (sram_ce_n || !sram_oe_n || !sram_data_oe)) viol++;
    if (!sram_oe_n && sram_ce_n) viol++;
    if (i_ack && d_ack) viol++;
    if (sram_addr[19:8] != 12'h0 || u0_addr[19:8] != 12'h0) viol++;
    if (u0_we_n !== 1'b1 || u0_doe !== 1'b0 || u0_d_ack !== 1'b0 || u0_data_o !== 32'h0) viol++;
    if (u0_oe_n ? (u0_be_n !== 4'hF) : (u0_be_n !== 4'h0)) viol++;
    if (u0_d_rdata !== 32'h0) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be_n);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) m = m | ((be_n[b] ? 32'h0 : 32'hFF) << (8 * b));
    return (old & ~m) | (wd & m);
  endfunction

  task automatic run_txn(input bit dp, input bit we, input logic [19:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] rd);
    lat = -1;
    rd = 32'h0;
    @(negedge clk);
    if (dp) begin d_we = we; d_addr = a; d_wdata = wd; d_be_n = be; d_req = 1'b1; end
    else begin i_addr = a; i_req = 1'b1; end
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        i_addr = 20'($urandom); d_addr = 20'($urandom); d_wdata = $urandom;
        d_be_n = 4'($urandom); d_we = 1'($urandom);
      end
      if (dp ? d_ack : i_ack) begin
        lat = n; rd = dp ? d_rdata : i_rdata; i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_be_n = 4'hF;
    i0_req = 0; i0_addr = 0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, i_ack, d_ack, i0_ack, sram_be_n} !== 11'b111_0000_1111) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected %b",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, i_ack, d_ack, i0_ack, sram_be_n}, 11'b111_0000_1111);
    end
    checks++;
    if ({sram_addr, sram_data_o, i_rdata, d_rdata} !== 116'h0) begin
      failures++;
      $display("FAIL reset_regs: got %h expected 0", {sram_addr, sram_data_o, i_rdata, d_rdata});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ifetch();
    @(negedge clk);
    i_addr = 20'h10; i_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        i_addr = 20'h55;
        checks++; if (sram_addr !== 20'h10) begin failures++; $display("FAIL ifetch_addr: got %h expected 00010", sram_addr); end
      end
      checks++;
      if (sram_oe_n !== !(n <= WC + 1)) begin failures++; $display("FAIL ifetch_oe_n c%0d: got %b expected %b", n, sram_oe_n, !(n <= WC + 1)); end
      checks++;
      if (i_ack !== (n == WC + 2)) begin failures++; $display("FAIL ifetch_ack c%0d: got %b expected %b", n, i_ack, n == WC + 2); end
      if (i_ack) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ifetch_data: got %h expected deadbeef", i_rdata); end
        i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    checks++; if (i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ifetch_hold: got %h expected deadbeef", i_rdata); end
  endtask

  task automatic test_write();
    @(negedge clk);
    d_addr = 20'h20; d_we = 1'b1; d_wdata = 32'h12345678; d_be_n = 4'b1100; d_req = 1'b1;
    ref_mem[8'h20] = merge(ref_mem[8'h20], 32'h12345678, 4'b1100);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin d_addr = 20'h21; d_wdata = 32'hFFFFFFFF; d_be_n = 4'h0; d_we = 1'b0; end
      checks++;
      if (sram_data_oe !== (n <= WC + 3)) begin failures++; $display("FAIL wr_data_oe c%0d: got %b expected %b", n, sram_data_oe, n <= WC + 3); end
      checks++;
      if (sram_we_n !== !(n >= 2 && n <= WC + 2)) begin failures++; $display("FAIL wr_we_n c%0d: got %b expected %b", n, sram_we_n, !(n >= 2 && n <= WC + 2)); end
      checks++;
      if (d_ack !== (n == WC + 3)) begin failures++; $display("FAIL wr_ack c%0d: got %b expected %b", n, d_ack, n == WC + 3); end
      if (n <= WC + 3) begin
        checks++; if (sram_be_n !== 4'b1100) begin failures++; $display("FAIL wr_be_n c%0d: got %b expected 1100", n, sram_be_n); end
      end
      if (d_ack) d_req = 1'b0;
    end
    d_req = 1'b0;
    checks++;
    if (smem[8'h20] !== ref_mem[8'h20]) begin failures++; $display("FAIL wr_mem: got %h expected %h", smem[8'h20], ref_mem[8'h20]); end
  endtask

  task automatic arb_pair(input bit i_first, input logic [19:0] ia, input logic [19:0] da);
    int il = 0, dl = 0;
    @(negedge clk);
    i_addr = ia; d_addr = da; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (i_ack && il == 0) begin
        il = n; i_req = 1'b0;
        checks++; if (i_rdata !== ref_mem[ia[7:0]]) begin failures++; $display("FAIL arb_i_data: got %h expected %h", i_rdata, ref_mem[ia[7:0]]); end
      end
      if (d_ack && dl == 0) begin
        dl = n; d_req = 1'b0;
        checks++; if (d_rdata !== ref_mem[da[7:0]]) begin failures++; $display("FAIL arb_d_data: got %h expected %h", d_rdata, ref_mem[da[7:0]]); end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (il !== (i_first ? WC + 2 : 2 * WC + 5)) begin failures++; $display("FAIL arb_i_cycle: got %0d expected %0d", il, i_first ? WC + 2 : 2 * WC + 5); end
    checks++;
    if (dl !== (i_first ? 2 * WC + 5 : WC + 2)) begin failures++; $display("FAIL arb_d_cycle: got %0d expected %0d", dl, i_first ? 2 * WC + 5 : WC + 2); end
  endtask

  task automatic test_arbitration();
    int lat;
    logic [31:0] rd;
    arb_pair(1'b0, 20'h10, 20'h20);
    run_txn(1'b1, 1'b0, 20'h30, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== ref_mem[8'h30]) begin failures++; $display("FAIL arb_lone_data: got %h expected %h", rd, ref_mem[8'h30]); end
`ifdef SRAM_RR_ARB_EN
    arb_pair(1'b1, 20'h11, 20'h21);
`else
    arb_pair(1'b0, 20'h11, 20'h21);
`endif
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [31:0] rd;
    logic seen = 1'b0;
    @(negedge clk);
    d_addr = 20'h40; d_we = 1'b1; d_wdata = 32'hCAFEF00D; d_be_n = 4'h0; d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL rstw_pulse: got %b expected 0", sram_we_n); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_we_n, sram_ce_n, sram_oe_n, sram_data_oe, d_ack} !== 5'b11100) begin
      failures++;
      $display("FAIL rstw_strobes: got %b expected 11100", {sram_we_n, sram_ce_n, sram_oe_n, sram_data_oe, d_ack});
    end
    d_req = 1'b0; d_we = 1'b0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); seen = seen | d_ack; end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin @(negedge clk); seen = seen | d_ack; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstw_no_ack: got %b expected 0", seen); end
    run_txn(1'b1, 1'b0, 20'h30, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== WC + 2) begin failures++; $display("FAIL rstw_read_lat: got %0d expected %0d", lat, WC + 2); end
    checks++; if (rd !== ref_mem[8'h30]) begin failures++; $display("FAIL rstw_read_data: got %h expected %h", rd, ref_mem[8'h30]); end
  endtask

  task automatic test_wait0();
    int lat = 0;
    logic [31:0] rd = 32'h0;
    @(negedge clk);
    i0_addr = 20'h10; i0_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (i0_ack && lat == 0) begin lat = n; rd = i0_rdata; i0_req = 1'b0; end
    end
    i0_req = 1'b0;
    checks++; if (lat !== 2) begin failures++; $display("FAIL wait0_lat: got %0d expected 2", lat); end
    checks++; if (rd !== ref_mem[8'h10]) begin failures++; $display("FAIL wait0_data: got %h expected %h", rd, ref_mem[8'h10]); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] addrs [4];
    int k = 0, last = 0;
    for (int j = 0; j < 4; j++) addrs[j] = 20'h80 + 20'(3 * j);
    @(negedge clk);
    d_we = 1'b0; d_addr = addrs[0]; d_req = 1'b1;
    for (int n = 1; n <= 40 && k < 4; n++) begin
      @(negedge clk);
      if (last != 0 && n == last + 1) begin
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL b2b_idle c%0d: got oe_n=%b expected 1", n, sram_oe_n); end
      end
      if (last != 0 && n == last + 2) begin
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL b2b_restart c%0d: got oe_n=%b expected 0", n, sram_oe_n); end
      end
      if (d_ack) begin
        checks++; if (d_rdata !== ref_mem[addrs[k][7:0]]) begin failures++; $display("FAIL b2b_data %0d: got %h expected %h", k, d_rdata, ref_mem[addrs[k][7:0]]); end
        checks++; if (n - last !== (k == 0 ? WC + 2 : WC + 3)) begin failures++; $display("FAIL b2b_spacing %0d: got %0d expected %0d", k, n - last, k == 0 ? WC + 2 : WC + 3); end
        last = n; k++;
        if (k < 4) d_addr = addrs[k]; else d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    checks++; if (k !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", k); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] rd, wd;
    logic [19:0] a;
    logic [3:0] be;
    bit dp, we;
    for (int t = 0; t < 60; t++) begin
      dp = 1'($urandom);
      we = dp && ($urandom_range(0, 2) == 0);
      a  = 20'h90 + 20'($urandom_range(0, 15));
      wd = $urandom;
      be = 4'($urandom);
      run_txn(dp, we, a, wd, be, lat, rd);
      checks++;
      if (lat !== (we ? WC + 3 : WC + 2)) begin failures++; $display("FAIL rand_lat %0d: got %0d expected %0d", t, lat, we ? WC + 3 : WC + 2); end
      if (we) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], wd, be);
      else begin
        checks++; if (rd !== ref_mem[a[7:0]]) begin failures++; $display("FAIL rand_data %0d: got %h expected %h", t, rd, ref_mem[a[7:0]]); end
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      smem[j] = {16'hA5A5, 8'(j), 8'(~j)};
      ref_mem[j] = {16'hA5A5, 8'(j), 8'(~j)};
    end
    smem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    smem[8'h20] = 32'hAAAAAAAA; ref_mem[8'h20] = 32'hAAAAAAAA;
    test_reset();
    test_ifetch();
    test_write();
    test_arbitration();
    test_reset_mid_write();
    test_wait0();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    checks++; if (viol !== 0) begin failures++; $display("FAIL protocol: got %0d violations expected 0", viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
